ftdi_tx_ctrl: RTL and testbench

FTDI_TX_CTRL -- requirements
Module: ftdi_tx_ctrl

---
 rtl/ftdi_pkg.sv | 16 +
 rtl/sync_fifo.sv | 64 ++++++
 rtl/ftdi_tx_ctrl.sv | 128 ++++++++++++
 tb/tb_ftdi_tx_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ftdi_pkg.sv
// Shared types and constants for the FTDI synchronous-FIFO transmit path.
package ftdi_pkg;

  localparam int FU_D_W            = 8;
  localparam int DEFAULT_DEPTH     = 16;
  localparam int DEFAULT_BURST_MAX = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TURN,
    ST_WRITE,
    ST_HOLD,
    ST_REL
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; exposes the head and the entry behind it so a
// registered consumer can present the next byte on the cycle after a pop.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] head_o,
  output logic [WIDTH-1:0] head_nxt_o,
  output logic [LW-1:0]    level_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full_o     = (level_q == LW'(DEPTH));
  assign empty_o    = (level_q == '0);
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign head_o     = mem_q[rd_ptr_q];
  assign head_nxt_o = mem_q[rd_ptr_q + AW'(1)];
  assign level_o    = level_q;

  // Pointers are AW bits wide over a power-of-two depth, so they wrap for free.
  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    if (do_push && !do_pop) level_d = level_q + LW'(1);
    if (do_pop && !do_push) level_d = level_q - LW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and level define
  // which entries are valid, and a reset here would block RAM inference.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ftdi_tx_ctrl.sv
// Transmit side of an FTDI 245 synchronous-FIFO bridge: buffers bytes and
// bursts them onto FU_D with a turnaround cycle on either side of each burst.
module ftdi_tx_ctrl
  import ftdi_pkg::*;
#(
  parameter  int DEPTH     = DEFAULT_DEPTH,
  parameter  int BURST_MAX = DEFAULT_BURST_MAX,
  localparam int LW        = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FU_D_W-1:0] d,
  input  logic              d_vld,
  output logic              d_rdy,
  input  logic              rd_busy,
  output logic              tx_busy,
  input  logic              txe_n,
  output logic              wr_n,
  output logic [FU_D_W-1:0] dq_o,
  output logic              dq_oe,
  output logic [LW-1:0]     level,
  output logic [15:0]       tx_cnt
);

  localparam int BW = $clog2(BURST_MAX + 1);

  tx_state_e         state_q, state_d;
  logic              wr_n_q, wr_n_d;
  logic              own_q, own_d;
  logic [FU_D_W-1:0] dq_o_q, dq_o_d;
  logic [15:0]       tx_cnt_q, tx_cnt_d;
  logic [BW-1:0]     burst_q, burst_d;

  logic [FU_D_W-1:0] fifo_head, fifo_head_nxt;
  logic              fifo_full, fifo_empty;
  logic              push, accept, last_byte;

  assign d_rdy  = !fifo_full;
  assign push   = d_vld && d_rdy;
  assign accept = !wr_n_q && !txe_n;

  sync_fifo #(
    .WIDTH(FU_D_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push),
    .pop_i     (accept),
    .wdata_i   (d),
    .head_o    (fifo_head),
    .head_nxt_o(fifo_head_nxt),
    .level_o   (level),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // The accept that drains the last entry ends the burst unless a byte is
  // being pushed on the same edge.
  assign last_byte = ((level == LW'(1)) && !push) || (burst_q == BW'(BURST_MAX - 1));

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    dq_o_d   = dq_o_q;
    tx_cnt_d = tx_cnt_q;
    burst_d  = burst_q;

    if (accept) begin
      tx_cnt_d = tx_cnt_q + 16'd1;
      burst_d  = burst_q + BW'(1);
      dq_o_d   = (level == LW'(1)) ? d : fifo_head_nxt;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !txe_n && !rd_busy) begin
          state_d = ST_TURN;
          dq_o_d  = fifo_head;
        end
      end
      ST_TURN:  state_d = ST_WRITE;
      ST_WRITE: begin
        if (txe_n)          state_d = ST_HOLD;
        else if (last_byte) state_d = ST_REL;
      end
      ST_HOLD: begin
        if (rd_busy || fifo_empty) state_d = ST_REL;
        else if (!txe_n)           state_d = ST_WRITE;
      end
      ST_REL: begin
        state_d = ST_IDLE;
        burst_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase

    // Bus-side outputs are decoded from the next state so they leave a flop.
    wr_n_d = (state_d != ST_WRITE);
    own_d  = (state_d inside {ST_TURN, ST_WRITE, ST_HOLD});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wr_n_q   <= 1'b1;
      own_q    <= 1'b0;
      dq_o_q   <= '0;
      tx_cnt_q <= '0;
      burst_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_n_q   <= wr_n_d;
      own_q    <= own_d;
      dq_o_q   <= dq_o_d;
      tx_cnt_q <= tx_cnt_d;
      burst_q  <= burst_d;
    end
  end

  assign wr_n    = wr_n_q;
  assign dq_o    = dq_o_q;
  assign dq_oe   = own_q;
  assign tx_busy = own_q;
  assign tx_cnt  = tx_cnt_q;

endmodule

// File: tb/tb_ftdi_tx_ctrl.sv
// Directed bench for ftdi_tx_ctrl: default instance plus a BURST_MAX=4 instance.
module tb_ftdi_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] d;
  logic       d_vld, d_rdy, rd_busy, tx_busy, txe_n, wr_n, dq_oe;
  logic [7:0] dq_o;
  logic [4:0] level;
  logic [15:0] tx_cnt;

  logic [7:0] d_b;
  logic       d_vld_b, d_rdy_b, rd_busy_b, tx_busy_b, txe_n_b, wr_n_b, dq_oe_b;
  logic [7:0] dq_o_b;
  logic [4:0] level_b;
  logic [15:0] tx_cnt_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ftdi_tx_ctrl dut (
    .clk(clk), .rst(rst), .d(d), .d_vld(d_vld), .d_rdy(d_rdy),
    .rd_busy(rd_busy), .tx_busy(tx_busy), .txe_n(txe_n), .wr_n(wr_n),
    .dq_o(dq_o), .dq_oe(dq_oe), .level(level), .tx_cnt(tx_cnt)
  );

  ftdi_tx_ctrl #(.BURST_MAX(4)) dut_b4 (
    .clk(clk), .rst(rst), .d(d_b), .d_vld(d_vld_b), .d_rdy(d_rdy_b),
    .rd_busy(rd_busy_b), .tx_busy(tx_busy_b), .txe_n(txe_n_b), .wr_n(wr_n_b),
    .dq_o(dq_o_b), .dq_oe(dq_oe_b), .level(level_b), .tx_cnt(tx_cnt_b)
  );

  // Byte capture as the FTDI sees it: WR# and TXE# both low at an edge.
  logic [7:0] got_q[$];
  int         acc_total = 0;
  always @(posedge clk) begin
    if (!rst && wr_n === 1'b0 && txe_n === 1'b0) begin
      got_q.push_back(dq_o);
      acc_total <= acc_total + 1;
    end
  end

  // Burst lengths and bus-release gaps of the BURST_MAX=4 instance.
  logic [7:0] got_b[$];
  int         blen_b[$];
  int         gap_b[$];
  int         cur_len_b = 0;
  int         low_run_b = 0;
  logic       oe_prev_b = 1'b0;
  always @(posedge clk) begin
    if (!rst && wr_n_b === 1'b0 && txe_n_b === 1'b0) begin
      got_b.push_back(dq_o_b);
      cur_len_b <= cur_len_b + 1;
    end
    if (dq_oe_b) begin
      if (!oe_prev_b && blen_b.size() > 0) gap_b.push_back(low_run_b);
      low_run_b <= 0;
    end else begin
      low_run_b <= low_run_b + 1;
      if (oe_prev_b) begin
        blen_b.push_back(cur_len_b);
        cur_len_b <= 0;
      end
    end
    oe_prev_b <= dq_oe_b;
  end

  task automatic check(input string tag, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int got_at(int i);
    return (i < got_q.size()) ? int'(got_q[i]) : -1;
  endfunction

  function automatic int got_b_at(int i);
    return (i < got_b.size()) ? int'(got_b[i]) : -1;
  endfunction

  function automatic int blen_at(int i);
    return (i < blen_b.size()) ? blen_b[i] : -1;
  endfunction

  initial begin
    #1_200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int pushes;
    int cyc;
    logic [7:0] exp3 [3];

    rst = 1'b1; d = '0; d_vld = 1'b0; rd_busy = 1'b0; txe_n = 1'b1;
    d_b = '0; d_vld_b = 1'b0; rd_busy_b = 1'b0; txe_n_b = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_wr_n",    int'(wr_n), 1);
    check("rst_dq_oe",   int'(dq_oe), 0);
    check("rst_dq_o",    int'(dq_o), 0);
    check("rst_tx_busy", int'(tx_busy), 0);
    check("rst_level",   int'(level), 0);
    check("rst_tx_cnt",  int'(tx_cnt), 0);
    rst = 1'b0;
    tick();
    check("rst_d_rdy", int'(d_rdy), 1);

    // Three-byte burst with the FTDI ready
    txe_n = 1'b0;
    base = got_q.size();
    d = 8'h11; d_vld = 1'b1; tick();
    check("s1_idle_busy", int'(tx_busy), 0);
    d = 8'h22; tick();
    check("s1_turn_busy", int'(tx_busy), 1);
    check("s1_turn_oe",   int'(dq_oe), 1);
    check("s1_turn_wr_n", int'(wr_n), 1);
    check("s1_turn_dq",   int'(dq_o), 'h11);
    d = 8'h33; tick();
    d_vld = 1'b0;
    check("s1_w0_wr_n", int'(wr_n), 0);
    check("s1_w0_dq",   int'(dq_o), 'h11);
    check("s1_w0_level", int'(level), 3);
    tick();
    check("s1_w1_wr_n", int'(wr_n), 0);
    check("s1_w1_dq",   int'(dq_o), 'h22);
    tick();
    check("s1_w2_wr_n", int'(wr_n), 0);
    check("s1_w2_dq",   int'(dq_o), 'h33);
    tick();
    check("s1_rel_wr_n",  int'(wr_n), 1);
    check("s1_rel_oe",    int'(dq_oe), 0);
    check("s1_rel_busy",  int'(tx_busy), 0);
    check("s1_tx_cnt",    int'(tx_cnt), 3);
    check("s1_level",     int'(level), 0);
    tick();
    exp3 = '{8'h11, 8'h22, 8'h33};
    check("s1_count", got_q.size() - base, 3);
    for (int i = 0; i < 3; i++) check("s1_order", got_at(base + i), int'(exp3[i]));

    // TXE# deasserts after the second accept: HOLD keeps byte 3 on the bus
    txe_n = 1'b1;
    base = got_q.size();
    for (int i = 0; i < 4; i++) begin
      d = 8'hA1 + 8'(i); d_vld = 1'b1; tick();
    end
    d_vld = 1'b0;
    check("s2_idle_level", int'(level), 4);
    check("s2_idle_busy",  int'(tx_busy), 0);
    txe_n = 1'b0;
    tick(); tick(); tick(); tick();
    check("s2_w_dq", int'(dq_o), 'hA3);
    txe_n = 1'b1;
    tick();
    check("s2_hold_wr_n",  int'(wr_n), 1);
    check("s2_hold_dq",    int'(dq_o), 'hA3);
    check("s2_hold_level", int'(level), 2);
    check("s2_hold_oe",    int'(dq_oe), 1);
    repeat (4) tick();
    check("s2_hold5_wr_n", int'(wr_n), 1);
    check("s2_hold5_dq",   int'(dq_o), 'hA3);
    txe_n = 1'b0;
    tick();
    check("s2_resume_wr_n", int'(wr_n), 0);
    check("s2_resume_dq",   int'(dq_o), 'hA3);
    tick();
    check("s2_last_dq", int'(dq_o), 'hA4);
    tick();
    check("s2_tx_cnt", int'(tx_cnt), 7);
    check("s2_level",  int'(level), 0);
    check("s2_count", got_q.size() - base, 4);
    for (int i = 0; i < 4; i++) check("s2_order", got_at(base + i), 'hA1 + i);

    // Fill to DEPTH; the 17th byte is refused
    txe_n = 1'b1;
    base = got_q.size();
    for (int i = 0; i < 16; i++) begin
      d = 8'h40 + 8'(i); d_vld = 1'b1; tick();
    end
    check("s3_full_level", int'(level), 16);
    check("s3_full_rdy",   int'(d_rdy), 0);
    d = 8'h50; tick();
    d_vld = 1'b0;
    check("s3_drop_level", int'(level), 16);
    txe_n = 1'b0;
    repeat (25) tick();
    check("s3_count",  got_q.size() - base, 16);
    check("s3_level",  int'(level), 0);
    check("s3_tx_cnt", int'(tx_cnt), 23);
    for (int i = 0; i < 16; i++) check("s3_order", got_at(base + i), 'h40 + i);

    // rd_busy holds IDLE; a push and rd_busy during WRITE extend the burst
    rd_busy = 1'b1;
    base = got_q.size();
    d = 8'hC0; d_vld = 1'b1; tick();
    d_vld = 1'b0;
    repeat (3) tick();
    check("s4_blocked_oe",   int'(dq_oe), 0);
    check("s4_blocked_busy", int'(tx_busy), 0);
    check("s4_blocked_lvl",  int'(level), 1);
    rd_busy = 1'b0;
    tick();
    check("s4_turn_busy", int'(tx_busy), 1);
    check("s4_turn_oe",   int'(dq_oe), 1);
    tick();
    check("s4_w_wr_n", int'(wr_n), 0);
    check("s4_w_dq",   int'(dq_o), 'hC0);
    d = 8'hC1; d_vld = 1'b1; rd_busy = 1'b1;
    tick();
    d_vld = 1'b0;
    check("s4_ext_wr_n",  int'(wr_n), 0);
    check("s4_ext_dq",    int'(dq_o), 'hC1);
    check("s4_ext_level", int'(level), 1);
    tick();
    check("s4_rel_oe",  int'(dq_oe), 0);
    check("s4_tx_cnt",  int'(tx_cnt), 25);
    rd_busy = 1'b0;
    tick();
    check("s4_count", got_q.size() - base, 2);
    check("s4_b0", got_at(base), 'hC0);
    check("s4_b1", got_at(base + 1), 'hC1);

    // BURST_MAX=4 instance: six bytes split 4 + 2 with a bus release between
    for (int i = 0; i < 6; i++) begin
      d_b = 8'hD0 + 8'(i); d_vld_b = 1'b1; tick();
    end
    d_vld_b = 1'b0;
    repeat (20) tick();
    check("b4_count",   got_b.size(), 6);
    for (int i = 0; i < 6; i++) check("b4_order", got_b_at(i), 'hD0 + i);
    check("b4_bursts",  blen_b.size(), 2);
    check("b4_len0",    blen_at(0), 4);
    check("b4_len1",    blen_at(1), 2);
    check("b4_gap_ge2", int'(gap_b.size() > 0 && gap_b[0] >= 2), 1);
    check("b4_tx_cnt",  int'(tx_cnt_b), 6);

    // Reset in the middle of a burst
    txe_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d = 8'hE0 + 8'(i); d_vld = 1'b1; tick();
    end
    d_vld = 1'b0;
    txe_n = 1'b0;
    tick(); tick(); tick(); tick();
    check("s6_pre_wr_n", int'(wr_n), 0);
    check("s6_pre_dq",   int'(dq_o), 'hE2);
    rst = 1'b1;
    tick();
    check("s6_wr_n",   int'(wr_n), 1);
    check("s6_oe",     int'(dq_oe), 0);
    check("s6_busy",   int'(tx_busy), 0);
    check("s6_level",  int'(level), 0);
    check("s6_tx_cnt", int'(tx_cnt), 0);
    check("s6_dq",     int'(dq_o), 0);
    rst = 1'b0;
    tick();
    check("s6_d_rdy", int'(d_rdy), 1);

    // 65536 accepted bytes wrap tx_cnt back to zero
    base = acc_total;
    pushes = 0;
    cyc = 0;
    txe_n = 1'b0;
    d = 8'h00; d_vld = 1'b1;
    while (pushes < 65536 && cyc < 90000) begin
      @(negedge clk);
      if (d_rdy) pushes++;
      @(posedge clk); #1;
      cyc++;
      d = 8'(pushes);
      if (pushes == 65536) d_vld = 1'b0;
    end
    d_vld = 1'b0;
    check("wrap_pushes", pushes, 65536);
    cyc = 0;
    while (acc_total - base < 65536 && cyc < 200) begin
      tick();
      cyc++;
    end
    repeat (3) tick();
    check("wrap_accepted", acc_total - base, 65536);
    check("wrap_tx_cnt",   int'(tx_cnt), 0);
    check("wrap_level",    int'(level), 0);
    check("wrap_oe",       int'(dq_oe), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
